// File: rtl/parking_pass_checker.sv
// Parking gate entry front end: sensor debounce, keypad code check, retries.
// Define PASS_LOCKOUT_EN to enable the retry limit and LOCKOUT state.
module parking_pass_checker #(
  parameter int          NDIGITS       = 4,
  parameter logic [31:0] CODE          = 32'h0000_1234,
  parameter int          DEBOUNCE      = 4,
  parameter int          ENTRY_TIMEOUT = 200,
  parameter int          MAX_TRIES     = 3,
  parameter int          LOCK_CYCLES   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic       car_in,
  output logic       pass_ok,
  output logic       fail,
  output logic       locked,
  output logic [2:0] attempts_left
);

  localparam int BW = 4 * NDIGITS;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
  localparam logic [BW-1:0] CODE_USED = CODE[BW-1:0];
  localparam logic [3:0]    LAST_DIG  = 4'(NDIGITS - 1);
  localparam logic [2:0]    TRIES     = 3'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    GRANT,
    LOCKOUT
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [2:0]    tries_d;
  logic          car_d, fail_d;

  logic          sens_db;
  logic [DW-1:0] db_cnt;
  logic          db_hit, db_rise, db_fall;
  logic          key_ok;

  // Edge events are decoded on the flipping sample so the FSM
  // reacts on the same edge that updates the debounced level.
  assign db_hit  = (sensor_raw != sens_db) && (db_cnt == DB_LAST);
  assign db_rise = db_hit && sensor_raw;
  assign db_fall = db_hit && !sensor_raw;
  assign key_ok  = key_valid && (key_digit <= 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      sens_db <= 1'b0;
      db_cnt  <= '0;
    end else if (sensor_raw == sens_db) begin
      db_cnt  <= '0;
    end else if (db_hit) begin
      sens_db <= sensor_raw;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    lcnt_d  = lcnt_q;
    tries_d = attempts_left;
    car_d   = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (db_rise) begin
          state_d = ENTRY;
          car_d   = 1'b1;
          buf_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      ENTRY: begin
        if (db_fall) begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key_ok) begin
          buf_d = (buf_q << 4) | BW'(key_digit);
          tmo_d = '0;
          if (cnt_q == LAST_DIG) begin
            state_d = CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        if (buf_q == CODE_USED) begin
          state_d = GRANT;
          tries_d = TRIES;
        end else begin
          fail_d  = 1'b1;
          buf_d   = '0;
          tmo_d   = '0;
          state_d = ENTRY;
`ifdef PASS_LOCKOUT_EN
          tries_d = attempts_left - 3'd1;
          if (attempts_left == 3'd1) begin
            state_d = LOCKOUT;
            lcnt_d  = '0;
          end
`endif
        end
      end
      GRANT: begin
        if (db_fall) begin
          state_d = IDLE;
          buf_d   = '0;
        end
      end
      LOCKOUT: begin
        if (lcnt_q == LOCK_LAST) begin
          state_d = IDLE;
          tries_d = TRIES;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      lcnt_q        <= '0;
      car_in        <= 1'b0;
      pass_ok       <= 1'b0;
      fail          <= 1'b0;
      locked        <= 1'b0;
      attempts_left <= TRIES;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      lcnt_q        <= lcnt_d;
      car_in        <= car_d;
      pass_ok       <= (state_d == GRANT);
      fail          <= fail_d;
      locked        <= (state_d == LOCKOUT);
      attempts_left <= tries_d;
    end
  end

endmodule

// File: doc/parking_pass_checker.md
# parking_pass_checker

Entry-side front end for the parking gate controller. Debounces the raw car-presence sensor into a single-cycle `car_in` pulse, collects keypad digits, compares them against a stored access code and drives `pass_ok` to the gate FSM. It also enforces a retry limit with a timed lockout. It sits between the physical sensor/keypad and the gate FSM, producing exactly the `car_in`/`pass_ok` pair that FSM consumes.

## Interface
- `NDIGITS`, 4: code length in digits (1..8).
- `CODE`, 32'h0000_1234: BCD access code; low `4*NDIGITS` bits used, first digit entered = most significant used nibble.
- `DEBOUNCE`, 4: consecutive equal sensor samples required to change debounced state (≥2).
- `ENTRY_TIMEOUT`, 200: idle cycles allowed between keys in ENTRY.
- `MAX_TRIES`, 3: wrong codes allowed before lockout (1..7).
- `LOCK_CYCLES`, 100: lockout duration in cycles.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `sensor_raw` in 1: raw car-presence sensor, asynchronous-ish, may bounce.
- `key_valid` in 1: one-cycle strobe, a key is presented.
- `key_digit` in 4: key value; 0..9 valid, 10..15 ignored.
- `car_in` out 1: one-cycle pulse on debounced car arrival.
- `pass_ok` out 1: level, code accepted, held through GRANT.
- `fail` out 1: one-cycle pulse on each wrong code.
- `locked` out 1: high during LOCKOUT.
- `attempts_left` out 3: remaining tries.

## Operation
- Reset: state IDLE; `car_in`, `pass_ok`, `fail`, `locked` = 0; `attempts_left` = MAX_TRIES; debounced sensor = 0; digit buffer, digit count, timers cleared.
- Debounce: counter counts consecutive samples differing from debounced value; reaching DEBOUNCE flips the debounced value and clears the counter. Any matching sample clears the counter.
- IDLE: debounced rising edge → `car_in` pulse, go ENTRY. Keys ignored.
- ENTRY: valid key (`key_valid` & digit ≤ 9) shifts the digit into the buffer, increments the count and reloads the timeout. On the NDIGITS-th digit → CHECK. Invalid digits are dropped and do not reload the timeout. Timeout expiry → clear buffer, go IDLE, no failure counted. Debounced falling edge (car gone) → IDLE and clear buffer. This takes priority over a same-cycle key.
- CHECK (one cycle): buffer == CODE → GRANT, `attempts_left` reloads to MAX_TRIES. Mismatch → `fail` pulse, `attempts_left` decrements. Result 0 → LOCKOUT, else → ENTRY with buffer cleared.
- GRANT: `pass_ok` = 1; keys ignored. Debounced falling edge → IDLE, `pass_ok` = 0.
- LOCKOUT: `locked` = 1, keys and sensor edges ignored (debouncer keeps running). After LOCK_CYCLES cycles → IDLE, `attempts_left` = MAX_TRIES. A car still present does not re-pulse `car_in`; a new rising edge is required.
- `car_in` never asserts outside the IDLE→ENTRY transition.

## Timing
- `sensor_raw` high on DEBOUNCE consecutive edges → `car_in` high for the cycle after the last of those edges.
- Final digit sampled at edge n → CHECK during cycle n..n+1 → `pass_ok`/`fail` visible after edge n+1 (2-edge latency).
- `pass_ok` falls after the edge that registers the debounced falling edge.
- `reset` mid-operation: all outputs take reset values after the next edge, regardless of state.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- `PASS_LOCKOUT_EN` defined: retry limit and LOCKOUT state as above.
- Undefined: LOCKOUT removed; mismatch always returns to ENTRY; `attempts_left` held at MAX_TRIES; `locked` tied 0; `fail` still pulses.

## Test plan
- Sensor bounces 1,0,1,1,1,1 → exactly one `car_in` pulse, after the 4th consecutive high; none during bounce.
- Car arrives, keys 1,2,3,4 → `pass_ok` = 1 two edges after the '4'. Sensor low for 4 cycles → `pass_ok` = 0, state IDLE.
- Car arrives, keys 9,9,9,9 → `fail` pulse, `attempts_left` 3→2. Then 1,2,3,4 → `pass_ok` = 1, `attempts_left` = 3.
- Three wrong codes → `locked` = 1 for 100 cycles, keys ignored, then `attempts_left` = 3. With `PASS_LOCKOUT_EN` undefined → `locked` stays 0.
- Keys 1,2 then 200 idle cycles → IDLE, buffer cleared; car removed then re-arrives → new `car_in`; 1,2,3,4 grants.
- `reset` asserted during GRANT → `pass_ok` = 0 next edge. Key 0xA during ENTRY ignored: 1,A,2,3,4 grants.
